// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide coprocessor sitting behind the
// register file. Operands come from the read ports A/B and the result is written
// back via C/Caddr/load. One bit is processed per CALC cycle.
//
// Ports:
//   clk, clear_n        clock (rising edge), asynchronous active-low reset
//   start, op           request (sampled in IDLE only), 0 = MUL, 1 = DIV
//   A, B                multiplicand/dividend, multiplier/divisor
//   dest_addr           destination register for the result
//   busy                high from the cycle after acceptance through the last writeback
//   done, div_zero      one-cycle pulses on the last writeback cycle
//   C, Caddr, load      register-file write port (C/Caddr hold outside writeback)
//
// Build option: define MULDIV_HI_EN to add a second writeback cycle (WB_HI) carrying
// the upper product half (MUL) or the remainder (DIV) to dest_addr+1.
module muldiv_unit #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic              op,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [WIDTH-1:0]  C,
    output logic [ADDR_W-1:0] Caddr,
    output logic              load
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_WB
`ifdef MULDIV_HI_EN
        , S_WB_HI
`endif
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                op_q;
    logic [WIDTH-1:0]    opnd_q;   // multiplicand for MUL, divisor for DIV
    logic [ACC_W-1:0]    acc_q;    // {hi, lo}: {product hi, product lo / multiplier} or {remainder, quotient}
    logic [ADDR_W-1:0]   dest_q;
    logic                busy_q;
    logic                done_q;
    logic                div_zero_q;
    logic [WIDTH-1:0]    c_q;
    logic [ADDR_W-1:0]   caddr_q;
    logic                load_q;

    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_shift;
    logic [WIDTH:0]      div_trial;
    logic [ACC_W-1:0]    acc_d;

    // One iteration: shift-add multiply (LSB of acc selects the add) or restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
        if (op_q) begin
            // A zero divisor always "fits", giving an all-ones quotient and remainder == dividend.
            if (div_trial[WIDTH]) begin
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            dest_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            c_q        <= '0;
            caddr_q    <= '0;
            load_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            load_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // busy_q still high here means the FSM only just returned; wait one cycle.
                    if (start && !busy_q) begin
                        op_q    <= op;
                        opnd_q  <= op ? B : A;
                        acc_q   <= {{WIDTH{1'b0}}, (op ? A : B)};
                        dest_q  <= dest_addr;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    load_q  <= 1'b1;
                    c_q     <= acc_q[WIDTH-1:0];
                    caddr_q <= dest_q;
`ifdef MULDIV_HI_EN
                    state_q <= S_WB_HI;
`else
                    done_q     <= 1'b1;
                    div_zero_q <= op_q && (opnd_q == '0);
                    state_q    <= S_IDLE;
`endif
                end
`ifdef MULDIV_HI_EN
                S_WB_HI: begin
                    load_q     <= 1'b1;
                    c_q        <= acc_q[ACC_W-1:WIDTH];
                    caddr_q    <= dest_q + ADDR_W'(1);
                    done_q     <= 1'b1;
                    div_zero_q <= op_q && (opnd_q == '0);
                    state_q    <= S_IDLE;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign C        = c_q;
    assign Caddr    = caddr_q;
    assign load     = load_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=16, ADDR_W=4).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  dest_addr = '0;
    logic        busy, done, div_zero, load;
    logic [15:0] C;
    logic [3:0]  Caddr;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef MULDIV_HI_EN
    localparam int N_WB = 2;
`else
    localparam int N_WB = 1;
`endif

    muldiv_unit #(.WIDTH(16), .ADDR_W(4)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .op(op), .A(A), .B(B),
        .dest_addr(dest_addr), .busy(busy), .done(done), .div_zero(div_zero),
        .C(C), .Caddr(Caddr), .load(load)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present a request for exactly one edge, then scramble the operand inputs.
    task automatic issue(input logic opv, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
        @(negedge clk);
        start = 1'b1; op = opv; A = a; B = b; dest_addr = d;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~opv; A = 16'hDEAD; B = 16'hBEEF; dest_addr = 4'hA;
    endtask

    // Count edges after acceptance until load is seen; -1 on timeout.
    task automatic wait_load(output int lat, output logic busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (load) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic do_op(input string name, input logic opv, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] d, input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                         input logic exp_dz);
        int   lat;
        logic bok;
        logic [3:0] dn;
        dn = d + 4'd1;
        issue(opv, a, b, d);
        wait_load(lat, bok);
        check({name, "_latency"}, 32'(lat), 32'd17);
        check({name, "_busy_run"}, 32'(bok), 32'd1);
        check({name, "_c"}, 32'(C), 32'(exp_lo));
        check({name, "_caddr"}, 32'(Caddr), 32'(d));
`ifdef MULDIV_HI_EN
        check({name, "_done_early"}, 32'(done), 32'd0);
        @(negedge clk);
        check({name, "_load_hi"}, 32'(load), 32'd1);
        check({name, "_c_hi"}, 32'(C), 32'(exp_hi));
        check({name, "_caddr_hi"}, 32'(Caddr), 32'(dn));
`else
        if (exp_hi !== exp_hi) check({name, "_x"}, 32'(exp_hi), 32'd0);
        if (dn !== dn) check({name, "_x"}, 32'(dn), 32'd0);
`endif
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_dz"}, 32'(div_zero), 32'(exp_dz));
        check({name, "_busy_wb"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({name, "_load_off"}, 32'(load), 32'd0);
        check({name, "_done_off"}, 32'(done), 32'd0);
        check({name, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   lat;
        int   nloads;
        logic bok;
        logic [15:0] first_c;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_c", 32'(C), 32'd0);
        check("rst_caddr", 32'(Caddr), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op("mul3x5",   1'b0, 16'd3,     16'd5,      4'd2,  16'h000F, 16'h0000, 1'b0);
        do_op("mul_wrap", 1'b0, 16'h1234,  16'h0010,   4'd15, 16'h2340, 16'h0001, 1'b0);
        do_op("div100_7", 1'b1, 16'd100,   16'd7,      4'd4,  16'h000E, 16'h0002, 1'b0);
        do_op("div_zero", 1'b1, 16'h00FF,  16'h0000,   4'd6,  16'hFFFF, 16'h00FF, 1'b1);
        do_op("mul_max",  1'b0, 16'hFFFF,  16'hFFFF,   4'd9,  16'h0001, 16'hFFFE, 1'b0);
        do_op("div_by1",  1'b1, 16'hFFFF,  16'h0001,   4'd0,  16'hFFFF, 16'h0000, 1'b0);
        do_op("div_small",1'b1, 16'd5,     16'd9,      4'd1,  16'h0000, 16'h0005, 1'b0);

        // Start while busy is ignored
        issue(1'b0, 16'd3, 16'd5, 4'd2);
        nloads = 0; bok = 1'b1; first_c = '0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 10) begin
                start = 1'b1; op = 1'b1; A = 16'd7; B = 16'd7; dest_addr = 4'd8;
            end
            if (i == 16) start = 1'b0;
            if (load) begin
                if (nloads == 0) first_c = C;
                nloads++;
            end
            if (i <= 18 && !busy) bok = 1'b0;
        end
        check("busy_ign_nloads", 32'(nloads), 32'(N_WB));
        check("busy_ign_c", 32'(first_c), 32'h000F);
        check("busy_ign_busy", 32'(bok), 32'd1);

        // Restart on the edge busy falls is rejected; accepted one cycle later
        issue(1'b0, 16'd2, 16'd3, 4'd1);
        wait_load(lat, bok);
        check("chain_first_c", 32'(C), 32'd6);
        if (N_WB == 2) @(negedge clk);
        start = 1'b1; op = 1'b1; A = 16'd81; B = 16'd9; dest_addr = 4'd3;
        @(negedge clk);
        check("chain_rejected", 32'(busy), 32'd0);
        @(negedge clk);
        check("chain_accepted", 32'(busy), 32'd1);
        start = 1'b0;
        wait_load(lat, bok);
        check("chain_latency", 32'(lat), 32'd16);
        check("chain_c", 32'(C), 32'd9);
        check("chain_caddr", 32'(Caddr), 32'd3);
        repeat (4) @(negedge clk);

        // Reset in the middle of CALC aborts the operation
        issue(1'b0, 16'd3, 16'd5, 4'd2);
        repeat (8) @(negedge clk);
        clear_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_c", 32'(C), 32'd0);
        check("abort_caddr", 32'(Caddr), 32'd0);
        check("abort_load", 32'(load), 32'd0);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        nloads = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (load) nloads++;
        end
        check("abort_no_load", 32'(nloads), 32'd0);
        do_op("post_abort", 1'b0, 16'd3, 16'd5, 4'd2, 16'h000F, 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
